// File: rtl/moore_seq_pkg.sv
// Shared constants, state-width helper and debug phase encoding for the
// parameterised Moore sequence detector.
package moore_seq_pkg;

  localparam int DEF_SEQ_W = 8;
  localparam int DEF_CNT_W = 16;

  // prog counts matched prefix bits 0..seq_w, so it needs one extra code point
  function automatic int prog_w(input int seq_w);
    return $clog2(seq_w + 1);
  endfunction

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_HUNT = 2'd1,
    PH_HIT  = 2'd2
  } det_phase_e;

endpackage

// File: rtl/moore_seq_detector_param_if.sv
// Control/data bundle for the sequence detector; prog and phase are debug
// views of the detector state.
interface moore_seq_detector_param_if
  import moore_seq_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int LEN_W = $clog2(SEQ_W + 1),
  parameter int CNT_W = DEF_CNT_W
);
  localparam int PW = prog_w(SEQ_W);

  logic             en;
  logic             x;
  logic             load;
  logic [SEQ_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             clear;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic [PW-1:0]    prog;
  det_phase_e       phase;

  modport master (
    output en, x, load, pattern, pat_len, overlap, clear,
    input  z, match_cnt, prog, phase
  );

  modport slave (
    input  en, x, load, pattern, pat_len, overlap, clear,
    output z, match_cnt, prog, phase
  );
endinterface

// File: rtl/moore_seq_next.sv
// Next-state logic: longest prefix of the pattern that is a suffix of the
// bits seen so far (the matched prefix followed by the new bit x).
module moore_seq_next
  import moore_seq_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int LEN_W = $clog2(SEQ_W + 1),
  parameter int PW    = prog_w(SEQ_W)
) (
  input  logic [PW-1:0]    prog,
  input  logic             x,
  input  logic [SEQ_W-1:0] pat_q,
  input  logic [LEN_W-1:0] len_q,
  input  logic             ovl_q,
  output logic [PW-1:0]    prog_nxt
);

  function automatic logic pat_bit(input logic [SEQ_W-1:0] v, input int idx);
    logic [SEQ_W-1:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic logic hist_bit(input logic [SEQ_W:0] v, input int idx);
    logic [SEQ_W:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  int             p;
  int             len;
  int             best;
  int             nxt;
  logic           ok;
  logic [SEQ_W:0] hist;

  always_comb begin
    p    = int'(prog);
    len  = int'(len_q);
    best = 0;
    nxt  = 0;
    ok   = 1'b0;
    // hist[0] is the newest bit; hist[i] for i>=1 replays the matched prefix
    hist = {{SEQ_W{1'b0}}, x};
    for (int i = 1; i <= SEQ_W; i++) begin
      if (i <= p)
        hist = hist | ((SEQ_W + 1)'(pat_bit(pat_q, len - p - 1 + i)) << i);
    end
    for (int k = 1; k <= SEQ_W; k++) begin
      if (k <= len && k <= p + 1) begin
        ok = 1'b1;
        for (int j = 0; j < SEQ_W; j++) begin
          if (j < k && hist_bit(hist, k - 1 - j) != pat_bit(pat_q, len - 1 - j))
            ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    if (len == 0)
      nxt = 0;
    else if (p >= len && !ovl_q)
      nxt = (x == pat_bit(pat_q, len - 1)) ? 1 : 0;
    else
      nxt = best;
    prog_nxt = PW'(nxt);
  end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parameterised Moore sequence detector with loadable pattern; the match
// counter exists only when SEQ_DET_MATCH_CNT_EN is defined.
module moore_seq_detector_param
  import moore_seq_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int LEN_W = $clog2(SEQ_W + 1),
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  moore_seq_detector_param_if.slave bus
);

  localparam int PW = prog_w(SEQ_W);

  logic [PW-1:0]    prog_q;
  logic [PW-1:0]    prog_nxt;
  logic [SEQ_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamp;
  logic             ovl_q;
  logic             hit;

  assign len_clamp = (int'(bus.pat_len) > SEQ_W) ? LEN_W'(SEQ_W) : bus.pat_len;

  moore_seq_next #(
    .SEQ_W(SEQ_W),
    .LEN_W(LEN_W),
    .PW   (PW)
  ) u_next (
    .prog    (prog_q),
    .x       (bus.x),
    .pat_q   (pat_q),
    .len_q   (len_q),
    .ovl_q   (ovl_q),
    .prog_nxt(prog_nxt)
  );

  // load takes priority over en: the x bit on a load edge is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_q <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b1;
    end else if (bus.load) begin
      prog_q <= '0;
      pat_q  <= bus.pattern;
      len_q  <= len_clamp;
      ovl_q  <= bus.overlap;
    end else if (bus.en) begin
      prog_q <= prog_nxt;
    end
  end

  assign bus.z    = (len_q != '0) && (int'(prog_q) == int'(len_q));
  assign bus.prog = prog_q;
  assign hit      = bus.en && !bus.load && (len_q != '0) &&
                    (int'(prog_nxt) == int'(len_q));

  always_comb begin
    bus.phase = PH_HUNT;
    if (len_q == '0) bus.phase = PH_OFF;
    else if (bus.z)  bus.phase = PH_HIT;
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (bus.clear)
      cnt_q <= '0;
    else if (hit && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.match_cnt = cnt_q;
`else
  logic unused_cnt_in;
  assign unused_cnt_in = bus.clear ^ hit;
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Bench for moore_seq_detector_param: directed scenarios plus random traffic
// checked against a bit-history reference model.
module tb_moore_seq_detector_param;
  localparam int SW = 8;
  localparam int LW = 4;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  moore_seq_detector_param_if #(.SEQ_W(SW), .CNT_W(16)) bus0 ();
  moore_seq_detector_param_if #(.SEQ_W(SW), .CNT_W(2))  bus1 ();

  moore_seq_detector_param #(.SEQ_W(SW), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  moore_seq_detector_param #(.SEQ_W(SW), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: raw history of sampled bits since the last load/match
  logic          m_hist[$];
  logic [SW-1:0] m_pat;
  int            m_len;
  logic          m_ovl;
  logic          m_z;
  int            m_cnt0;
  int            m_cnt1;
  logic [18:0]   exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_hist.delete();
    m_pat  = '0;
    m_len  = 0;
    m_ovl  = 1'b1;
    m_z    = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endfunction

  function automatic logic window_match();
    int n;
    logic [SW-1:0] t;
    n = m_hist.size();
    if (m_len == 0 || n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      t = m_pat >> (m_len - 1 - i);
      if (m_hist[n - m_len + i] != t[0]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step(input logic en, input logic x, input logic ld,
                                     input logic clr, input logic [SW-1:0] pat,
                                     input int len, input logic ovl);
    logic [15:0] e0;
    logic [1:0]  e1;
    if (ld) begin
      m_pat = pat;
      m_len = (len > SW) ? SW : len;
      m_ovl = ovl;
      m_hist.delete();
      m_z = 1'b0;
    end else if (en) begin
      m_hist.push_back(x);
      if (m_hist.size() > SW) void'(m_hist.pop_front());
      m_z = window_match();
      if (m_z) begin
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 3) m_cnt1++;
        if (!m_ovl) m_hist.delete();
      end
    end
    if (clr) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end
    e0 = CNT_ON ? 16'(m_cnt0) : 16'd0;
    e1 = CNT_ON ? 2'(m_cnt1) : 2'd0;
    exp_q.push_back({m_z, e0, e1});
  endfunction

  task automatic drive(input logic en, input logic x, input logic ld, input logic clr,
                       input logic [SW-1:0] pat, input int len, input logic ovl,
                       input string tag);
    logic [18:0] e;
    @(negedge clk);
    bus0.en = en;  bus0.x = x;  bus0.load = ld;  bus0.clear = clr;
    bus0.pattern = pat;  bus0.pat_len = LW'(len);  bus0.overlap = ovl;
    bus1.en = en;  bus1.x = x;  bus1.load = ld;  bus1.clear = clr;
    bus1.pattern = pat;  bus1.pat_len = LW'(len);  bus1.overlap = ovl;
    @(posedge clk);
    model_step(en, x, ld, clr, pat, len, ovl);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".z0"},   32'(bus0.z),         32'(e[18]));
    chk({tag, ".cnt0"}, 32'(bus0.match_cnt), 32'(e[17:2]));
    chk({tag, ".z1"},   32'(bus1.z),         32'(e[18]));
    chk({tag, ".cnt1"}, 32'(bus1.match_cnt), 32'(e[1:0]));
  endtask

  task automatic load_pat(input logic [SW-1:0] pat, input int len, input logic ovl);
    drive(1'b0, 1'b0, 1'b1, 1'b0, pat, len, ovl, "load");
  endtask

  task automatic bit_in(input logic x, input string tag);
    drive(1'b1, x, 1'b0, 1'b0, '0, 0, 1'b0, tag);
  endtask

  task automatic stall(input string tag);
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 0, 1'b0, tag);
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, 0, 1'b0, "clear");
  endtask

  task automatic feed(input logic [SW-1:0] bits, input int n, input string tag);
    logic [SW-1:0] t;
    for (int i = n - 1; i >= 0; i--) begin
      t = bits >> i;
      bit_in(t[0], tag);
    end
  endtask

  task automatic idle_inputs();
    bus0.en = 0; bus0.x = 0; bus0.load = 0; bus0.clear = 0;
    bus0.pattern = '0; bus0.pat_len = '0; bus0.overlap = 0;
    bus1.en = 0; bus1.x = 0; bus1.load = 0; bus1.clear = 0;
    bus1.pattern = '0; bus1.pat_len = '0; bus1.overlap = 0;
  endtask

  initial begin
    logic [SW-1:0] rp;
    idle_inputs();
    model_reset();

    // asynchronous reset in the middle of a clock period
    #1 rst_n = 1'b0;
    #2;
    chk("rst.z0",   32'(bus0.z),         32'd0);
    chk("rst.cnt0", 32'(bus0.match_cnt), 32'd0);
    chk("rst.z1",   32'(bus1.z),         32'd0);
    chk("rst.cnt1", 32'(bus1.match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1010 overlapping on 1010101: matches after bits 4 and 6
    load_pat(8'b1010, 4, 1'b1);
    feed(8'b1010101, 7, "ovl1010");
    chk("ovl1010.total", 32'(bus0.match_cnt), CNT_ON ? 32'd2 : 32'd0);
    do_clear();

    // same stimulus, non-overlapping: only one match
    load_pat(8'b1010, 4, 1'b0);
    feed(8'b1010101, 7, "novl1010");
    chk("novl1010.total", 32'(bus0.match_cnt), CNT_ON ? 32'd1 : 32'd0);
    do_clear();

    // 1101 on 11101: fallback from 111 keeps prog at 2
    load_pat(8'b1101, 4, 1'b1);
    feed(8'b11101, 5, "fb1101");
    chk("fb1101.z", 32'(bus0.z), 32'd1);
    chk("fb1101.total", 32'(bus0.match_cnt), CNT_ON ? 32'd1 : 32'd0);
    do_clear();

    // stall between bits 2 and 3
    load_pat(8'b1010, 4, 1'b1);
    bit_in(1'b1, "stl.b1");
    bit_in(1'b0, "stl.b2");
    for (int i = 0; i < 3; i++) stall("stl.gap");
    bit_in(1'b1, "stl.b3");
    bit_in(1'b0, "stl.b4");
    chk("stl.z", 32'(bus0.z), 32'd1);

    // zero length disables detection
    load_pat(8'b0, 0, 1'b1);
    for (int i = 0; i < 12; i++) bit_in(1'($urandom_range(0, 1)), "len0");
    chk("len0.z", 32'(bus0.z), 32'd0);
    do_clear();

    // saturation of the narrow counter, then clear beating a match
    load_pat(8'b11, 2, 1'b1);
    feed(8'b111111, 6, "sat");
    chk("sat.cnt0", 32'(bus0.match_cnt), CNT_ON ? 32'd5 : 32'd0);
    chk("sat.cnt1", 32'(bus1.match_cnt), CNT_ON ? 32'd3 : 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, 0, 1'b0, "clrwin");
    chk("clrwin.z", 32'(bus0.z), 32'd1);
    chk("clrwin.cnt", 32'(bus0.match_cnt), 32'd0);

    // pat_len above SEQ_W is clamped
    load_pat(8'hA5, 12, 1'b1);
    feed(8'hA5, 8, "clamp");
    chk("clamp.z", 32'(bus0.z), 32'd1);

    // reset mid-sequence drops progress and the loaded pattern
    load_pat(8'b1010, 4, 1'b1);
    feed(8'b101, 3, "mid");
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.z",   32'(bus0.z),         32'd0);
    chk("midrst.cnt", 32'(bus0.match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    feed(8'b01010, 5, "postrst");
    chk("postrst.z", 32'(bus0.z), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        rp = 8'($urandom);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
              rp, $urandom_range(0, 10), 1'($urandom_range(0, 1)), "rnd.load");
      end else begin
        drive(($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)), 1'b0,
              ($urandom_range(0, 99) < 3), '0, 0, 1'b0, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector_param.md
MOORE_SEQ_DETECTOR_PARAM -- requirements
Module: moore_seq_detector_param

Interface
REQ-001 Parameter SEQ_W, default 8, maximum pattern length in bits (2..32).
REQ-002 Parameter LEN_W, default $clog2(SEQ_W+1), width of the pattern-length port.
REQ-003 Parameter CNT_W, default 16, match-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  sample-enable; x consumed only on edges where en=1.
REQ-007 x  input  1  serial input bit.
REQ-008 load  input  1  latch pattern/pat_len/overlap on this edge.
REQ-009 pattern  input  SEQ_W  target sequence; bit pat_len-1 is received first, bit 0 last.
REQ-010 pat_len  input  LEN_W  active pattern length.
REQ-011 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 clear  input  1  synchronous clear of match_cnt.
REQ-013 z  output  1  Moore match output.
REQ-014 match_cnt  output  CNT_W  number of detected matches.

Function
REQ-015 State register prog holds matched-prefix length 0..len_q; len_q, pat_q, ovl_q are registered copies taken on load.
REQ-016 z SHALL be decoded from prog alone (z = prog==len_q and len_q!=0), never from x.
REQ-017 Latency: z rises for the cycle after the edge sampling the last pattern bit.
REQ-018 In prog<len_q, next prog = longest k such that the last k sampled bits equal the first k pattern bits (full fallback, not reset to 0).
REQ-019 From prog==len_q with ovl_q=1, fallback SHALL use the longest proper suffix-prefix overlap plus the new bit.
REQ-020 From prog==len_q with ovl_q=0, next prog = 1 if x equals first pattern bit, else 0.
REQ-021 en=0: prog, z, match_cnt hold.
REQ-022 load=1: registers updated, prog forced to 0 on the same edge; x on that edge is ignored.
REQ-023 pat_len=0 SHALL disable detection (z stays 0); pat_len>SEQ_W SHALL be clamped to SEQ_W.
REQ-024 match_cnt increments on each edge where next prog==len_q and en=1; saturates at all-ones.
REQ-025 clear and an increment on the same edge: clear wins, result 0.

Reset
REQ-026 rst_n low: prog=0, z=0, match_cnt=0, len_q=0, pat_q=0, ovl_q=1, immediately and asynchronously.
REQ-027 Reset assertion mid-sequence SHALL discard partial progress; detection after release restarts from prog=0 and needs a new load.

Configuration
REQ-028 Macro SEQ_DET_MATCH_CNT_EN defined: counter per REQ-024/025 built.
REQ-029 Macro SEQ_DET_MATCH_CNT_EN undefined: no counter flops, match_cnt tied to 0, clear ignored.

Structure
REQ-030 Package moore_seq_pkg SHALL hold default SEQ_W/CNT_W constants and a state-width function.
REQ-031 Combinational sub-module moore_seq_next SHALL compute next prog from prog, x, pat_q, len_q, ovl_q; the top holds only registers and counter.

Verification
REQ-032 Reset: rst_n=0 at t=1 mid-clock -> z=0, match_cnt=0 before next edge.
REQ-033 load pattern=1010, pat_len=4, overlap=1; x=1,0,1,0,1,0,1 -> z high after bits 4 and 6, match_cnt=2.
REQ-034 Same stimulus, overlap=0 -> z high only after bit 4, match_cnt=1.
REQ-035 pattern=1101, pat_len=4, overlap=1, x=1,1,1,0,1 -> z high after bit 5 (fallback 111 -> prog 2), match_cnt=1.
REQ-036 en=0 inserted between bits 2 and 3 of 1010 -> match still detected, z delayed by stall length.
REQ-037 pat_len=0 with any x -> z never asserts; CNT_W=2 with 5 matches -> match_cnt=3 (saturated); clear with coincident match -> match_cnt=0.
